bcd_display_scan: RTL and testbench

- Multiplexed 7-segment display driver that consumes packed BCD digits from the counter chain and scans them onto a common-anode display.
- Sits between the BCD counters and the board's segment/digit pins.
- Uses a tear-free double-buffered digit latch, a refresh divider, per-digit decode, invalid-code and error display.

---
 rtl/bcd_display_scan.sv | 113 +++++++++++
 tb/tb_bcd_display_scan.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Multiplexed common-anode 7-seg scanner with double-buffered BCD latch; outputs registered (1 cycle), no backpressure.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_display_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [4*NUM_DIGITS-1:0]   bcd_in,
  input  logic                      load,
  input  logic                      error,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     digit_en
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = 4 * NUM_DIGITS;

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [BW-1:0]         r_shadow;
  logic [BW-1:0]         r_latch;
  logic                  r_err;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_dig_en;

  logic                  w_wrap;
  logic                  w_last;
  logic [3:0]            w_digit;
  logic [NUM_DIGITS-1:0] w_en_n;
  logic                  w_blank;
  logic [6:0]            w_code;

  function automatic logic [6:0] decode7(input logic [3:0] d);
    case (d)
      4'd0:    decode7 = 7'h3F;
      4'd1:    decode7 = 7'h06;
      4'd2:    decode7 = 7'h5B;
      4'd3:    decode7 = 7'h4F;
      4'd4:    decode7 = 7'h66;
      4'd5:    decode7 = 7'h6D;
      4'd6:    decode7 = 7'h7D;
      4'd7:    decode7 = 7'h07;
      4'd8:    decode7 = 7'h7F;
      4'd9:    decode7 = 7'h6F;
      default: decode7 = 7'h40;
    endcase
  endfunction

  assign w_wrap = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_last = (r_idx == IW'(NUM_DIGITS - 1));

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;
    zero_run = 1'b1;
`endif
    w_digit = 4'd0;
    w_en_n  = '1;
    w_blank = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
      // zero_run holds while digit k and everything above it is zero
      zero_run = zero_run && (r_latch[4*k +: 4] == 4'd0);
`endif
      if (r_idx == IW'(k)) begin
        w_digit   = r_latch[4*k +: 4];
        w_en_n[k] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank   = zero_run && (k != 0);
`endif
      end
    end
  end

  assign w_code = r_err ? 7'h79 : (w_blank ? 7'h00 : decode7(w_digit));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_latch  <= '0;
      r_err    <= 1'b0;
      r_seg    <= 7'h7F;
      r_dp     <= 1'b1;
      r_dig_en <= '1;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      if (w_wrap) r_idx <= w_last ? '0 : r_idx + IW'(1);
      if (load) r_shadow <= bcd_in;
      // latch swaps only at frame end so a frame never mixes old and new digits
      if (w_wrap && w_last) r_latch <= r_shadow;
      r_err <= error;
      r_dp  <= 1'b1;
      if (w_wrap) begin
        r_seg    <= 7'h7F;
        r_dig_en <= '1;
      end else begin
        r_seg    <= ~w_code;
        r_dig_en <= w_en_n;
      end
    end
  end

  assign seg      = r_seg;
  assign dp       = r_dp;
  assign digit_en = r_dig_en;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan with NUM_DIGITS=4, REFRESH_DIV=4 (16-cycle frames).
module tb_bcd_display_scan;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FR = ND * RD;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bcd_in = 16'h0;
  logic        load = 1'b0;
  logic        error = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_en;

  int total = 0;
  int bad = 0;
  int cyc;
  logic [27:0] exp_q[$];

  bcd_display_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clock(clock), .reset_n(reset_n), .bcd_in(bcd_in), .load(load),
    .error(error), .seg(seg), .dp(dp), .digit_en(digit_en)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [27:0] frame_of(input logic [15:0] v);
    logic [27:0] f;
    logic z;
    z = 1'b1;
    f = '0;
    for (int k = 3; k >= 0; k--) begin
      z = z && (v[4*k +: 4] == 4'd0);
      f[7*k +: 7] = seg_of(v[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (z && k > 0) f[7*k +: 7] = 7'h7F;
`endif
    end
    return f;
  endfunction

  function automatic logic [3:0] en_of(input int slot);
    logic [3:0] e;
    e = 4'hF;
    if (slot % RD != RD - 1) e[slot / RD] = 1'b0;
    return e;
  endfunction

  function automatic int slot_now();
    return (cyc - 1) % FR;
  endfunction

  task automatic goto_slot(input int s);
    int n = 0;
    while (!(cyc > 0 && slot_now() == s) && n < 64) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n >= 64) begin
      bad++;
      $display("FAIL goto_slot: slot %0d never reached, cyc=%0d", s, cyc);
    end
  endtask

  task automatic check_frame(input string name);
    logic [27:0] f;
    logic [6:0]  es;
    goto_slot(0);
    f = exp_q.pop_front();
    for (int j = 0; j < FR; j++) begin
      if (j > 0) @(negedge clock);
      es = (j % RD == RD - 1) ? 7'h7F : f[(j / RD) * 7 +: 7];
      total++;
      if (digit_en !== en_of(j)) begin
        bad++;
        $display("FAIL %s en slot%0d: got %b want %b", name, j, digit_en, en_of(j));
      end
      total++;
      if (seg !== es) begin
        bad++;
        $display("FAIL %s seg slot%0d: got %h want %h", name, j, seg, es);
      end
      total++;
      if (dp !== 1'b1) begin
        bad++;
        $display("FAIL %s dp slot%0d: got %b want 1", name, j, dp);
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bcd_in = v;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    bcd_in = 16'hFFFF;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++;
    if (seg !== 7'h7F) begin bad++; $display("FAIL reset seg: got %h want 7f", seg); end
    total++;
    if (digit_en !== 4'hF) begin bad++; $display("FAIL reset en: got %b want 1111", digit_en); end
    total++;
    if (dp !== 1'b1) begin bad++; $display("FAIL reset dp: got %b want 1", dp); end
    reset_n = 1'b1;
    exp_q.push_back(frame_of(16'h0000));
    exp_q.push_back(frame_of(16'h0000));
    check_frame("post_reset0");
    check_frame("post_reset1");
  endtask

  task automatic test_load_mid();
    goto_slot(5);
    do_load(16'h1234);
    while (slot_now() != FR - 1) begin
      if (slot_now() % RD != RD - 1) begin
        total++;
        if (seg !== 7'h40) begin
          bad++;
          $display("FAIL no_tear slot%0d: got %h want 40", slot_now(), seg);
        end
      end
      @(negedge clock);
    end
    exp_q.push_back(frame_of(16'h1234));
    check_frame("load_1234");
  endtask

  task automatic test_boundary_load();
    goto_slot(FR - 2);
    do_load(16'h00A7);
    exp_q.push_back(frame_of(16'h1234));
    exp_q.push_back(frame_of(16'h00A7));
    check_frame("boundary_old");
    check_frame("boundary_new");
  endtask

  task automatic test_error();
    logic [27:0] f;
    logic [6:0]  es;
    int s;
    goto_slot(2);
    do_load(16'h0009);
    f = frame_of(16'h0009);
    exp_q.push_back(f);
    check_frame("show_0009");
    error = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      s = slot_now();
      total++;
      if (digit_en !== en_of(s)) begin
        bad++;
        $display("FAIL err_scan i%0d: got %b want %b", i, digit_en, en_of(s));
      end
      if (i >= 2) begin
        es = (s % RD == RD - 1) ? 7'h7F : 7'h06;
        total++;
        if (seg !== es) begin bad++; $display("FAIL err_seg i%0d: got %h want %h", i, seg, es); end
      end
    end
    error = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      s = slot_now();
      if (i >= 2) begin
        es = (s % RD == RD - 1) ? 7'h7F : f[(s / RD) * 7 +: 7];
        total++;
        if (seg !== es) begin bad++; $display("FAIL err_release i%0d: got %h want %h", i, seg, es); end
      end
    end
  endtask

  task automatic test_blank();
    goto_slot(3);
    do_load(16'h0000);
    exp_q.push_back(frame_of(16'h0000));
    check_frame("zeros");
    goto_slot(7);
    do_load(16'h0105);
    exp_q.push_back(frame_of(16'h0105));
    check_frame("show_0105");
  endtask

  task automatic test_reset_mid();
    goto_slot(9);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (seg !== 7'h7F) begin bad++; $display("FAIL async_reset seg: got %h want 7f", seg); end
    total++;
    if (digit_en !== 4'hF) begin bad++; $display("FAIL async_reset en: got %b want 1111", digit_en); end
    @(negedge clock);
    reset_n = 1'b1;
    exp_q.push_back(frame_of(16'h0000));
    exp_q.push_back(frame_of(16'h0000));
    check_frame("restart0");
    check_frame("restart1");
  endtask

  initial begin
    test_reset();
    test_load_mid();
    test_boundary_load();
    test_error();
    test_blank();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
